// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and per-word line overhead
// (start + 4 stop bits), common to the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    localparam int UART_OVERHEAD = 5;

endpackage

// File: rtl/uart_rx_if.sv
// Frame output handshake between uart_rx (master) and its consumer (slave).
interface uart_rx_if #(
    parameter int NUM_WORDS     = 2,
    parameter int BITS_PER_WORD = 8
);
    import uart_pkg::*;

    logic                                      m_valid;
    logic                                      m_ready;
    logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]   m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/uart_rx_byte.sv
// Single-word UART receiver: rx synchronizer, IDLE/START/DATA/STOP FSM and
// mid-bit sampler. Stop bit is checked only when UART_RX_FRAME_ERR_EN is defined.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int PACKET_SIZE      = 13
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   rx,
    output logic [PACKET_SIZE-UART_OVERHEAD-1:0]   word,
    output logic                                   word_vld,
    output logic                                   err
);
    localparam int BITS = PACKET_SIZE - UART_OVERHEAD;
    localparam int CW   = $clog2(CLOCKS_PER_PULSE);
    localparam int BW   = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CW-1:0] C_HALF = CW'(CLOCKS_PER_PULSE/2 - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BITS - 1);

    logic [1:0]      sync;
    logic            rx_s;
    rx_state_e       state, state_n;
    logic [CW-1:0]   c_cnt, c_cnt_n;
    logic [BW-1:0]   b_cnt, b_cnt_n;
    logic [BITS-1:0] shreg, shreg_n;
    logic            vld_n, err_n;

    assign rx_s = sync[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync     <= 2'b11;
            state    <= IDLE;
            c_cnt    <= '0;
            b_cnt    <= '0;
            shreg    <= '0;
            word_vld <= 1'b0;
            err      <= 1'b0;
        end else begin
            sync     <= {sync[0], rx};
            state    <= state_n;
            c_cnt    <= c_cnt_n;
            b_cnt    <= b_cnt_n;
            shreg    <= shreg_n;
            word_vld <= vld_n;
            err      <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        c_cnt_n = c_cnt + 1'b1;
        b_cnt_n = b_cnt;
        shreg_n = shreg;
        vld_n   = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                c_cnt_n = '0;
                b_cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                // A start bit that is gone by mid-bit is treated as a glitch.
                if (c_cnt == C_HALF) begin
                    c_cnt_n = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (c_cnt == C_LAST) begin
                    c_cnt_n = '0;
                    shreg_n = {rx_s, shreg[BITS-1:1]};
                    if (b_cnt == B_LAST) begin
                        b_cnt_n = '0;
                        state_n = STOP;
                    end else begin
                        b_cnt_n = b_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                // Trailing stop bits are simply idle-high time seen in IDLE.
                if (c_cnt == C_LAST) begin
                    c_cnt_n = '0;
                    vld_n   = 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
                    err_n   = !rx_s;
`endif
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign word = shreg;

endmodule

// File: rtl/uart_rx.sv
// UART frame receiver: assembles NUM_WORDS words into a frame and offers it on
// a valid/ready handshake. Optional stop-bit checking: UART_RX_FRAME_ERR_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int R_I              = 7,
    parameter int C_I              = 7,
    parameter int W_I              = 8,
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    uart_rx_if.master  m_if,
    output logic       frame_err,
    output logic       overrun
);
    localparam int W_OUT       = R_I * C_I * W_I;
    localparam int NUM_WORDS   = W_OUT / BITS_PER_WORD;
    localparam int PACKET_SIZE = BITS_PER_WORD + UART_OVERHEAD;
    localparam int WC          = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [WC-1:0] W_LAST = WC'(NUM_WORDS - 1);

    logic [BITS_PER_WORD-1:0]                word;
    logic                                    word_vld;
    logic                                    word_err;
    logic [WC-1:0]                           w_cnt;
    logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] asm_buf, frame_next;
    logic                                    frame_done;

    uart_rx_byte #(
        .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE),
        .PACKET_SIZE      (PACKET_SIZE)
    ) u_byte (
        .clk      (clk),
        .rstn     (rstn),
        .rx       (rx),
        .word     (word),
        .word_vld (word_vld),
        .err      (word_err)
    );

    // The last word is merged here so a completed frame can be offered in
    // the same cycle it is stored.
    always_comb begin
        frame_next        = asm_buf;
        frame_next[w_cnt] = word;
    end

    assign frame_done = word_vld && (w_cnt == W_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            asm_buf      <= '0;
            w_cnt        <= '0;
            m_if.m_valid <= 1'b0;
            m_if.m_data  <= '0;
            overrun      <= 1'b0;
        end else begin
            if (word_vld) begin
                asm_buf[w_cnt] <= word;
                w_cnt          <= (w_cnt == W_LAST) ? '0 : w_cnt + 1'b1;
            end
            if (frame_done && (!m_if.m_valid || m_if.m_ready)) begin
                m_if.m_data  <= frame_next;
                m_if.m_valid <= 1'b1;
            end else if (m_if.m_valid && m_if.m_ready) begin
                m_if.m_valid <= 1'b0;
            end
            // The line cannot be paused, so a frame with nowhere to go is lost.
            if (frame_done && m_if.m_valid && !m_if.m_ready)
                overrun <= 1'b1;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                    frame_err <= 1'b0;
        else if (word_vld && word_err) frame_err <= 1'b1;
    end
`else
    logic unused_err;
    assign unused_err = word_err;
    assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a 2-word frame (R_I=1, C_I=2, W_I=8, 4 clk/bit).
module tb_uart_rx;
    localparam int CPP  = 4;
    localparam int NW   = 2;
    localparam int BPW  = 8;

    logic clk = 1'b0;
    logic rstn;
    logic rx;
    logic frame_err, overrun;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   valid_cycles = 0;

    uart_rx_if #(.NUM_WORDS(NW), .BITS_PER_WORD(BPW)) bus ();

    uart_rx #(
        .R_I(1), .C_I(2), .W_I(8), .CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(BPW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .m_if      (bus.master),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.m_valid) valid_cycles <= valid_cycles + 1;

    task automatic tx_word(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        repeat (CPP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPP) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPP) @(negedge clk);
        rx = 1'b1;
        repeat (3*CPP) @(negedge clk);
    endtask

    task automatic tx_frame(input logic [7:0] w0, input logic [7:0] w1);
        tx_word(w0, 1'b1);
        tx_word(w1, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; rx = 1'b1; bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.m_valid); end
        n_checks++; if (bus.m_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", bus.m_data); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int base;
        bus.m_ready = 1'b1;
        base = valid_cycles;
        tx_frame(8'hA5, 8'h3C);
        n_checks++; if (valid_cycles - base !== 1) begin n_fail++; $display("FAIL basic_valid_pulse: got %0d cycles expected 1", valid_cycles - base); end
        n_checks++; if (bus.m_data[0] !== 8'hA5) begin n_fail++; $display("FAIL basic_word0: got %h expected a5", bus.m_data[0]); end
        n_checks++; if (bus.m_data[1] !== 8'h3C) begin n_fail++; $display("FAIL basic_word1: got %h expected 3c", bus.m_data[1]); end
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_low: got %b expected 0", bus.m_valid); end
    endtask

    task automatic test_loopback();
        logic [15:0] s_data;
        s_data = 16'h3CA5;
        bus.m_ready = 1'b1;
        tx_frame(s_data[7:0], s_data[15:8]);
        n_checks++; if (bus.m_data !== 16'h3CA5) begin n_fail++; $display("FAIL loopback_data: got %h expected 3ca5", bus.m_data); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL loopback_frame_err: got %b expected 0", frame_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL loopback_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_glitch();
        int base;
        bus.m_ready = 1'b1;
        base = valid_cycles;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++; if (valid_cycles - base !== 0) begin n_fail++; $display("FAIL glitch_no_valid: got %0d cycles expected 0", valid_cycles - base); end
        // A following frame must still land at word 0.
        tx_frame(8'h5A, 8'hC3);
        n_checks++; if (bus.m_data[0] !== 8'h5A) begin n_fail++; $display("FAIL glitch_word0: got %h expected 5a", bus.m_data[0]); end
        n_checks++; if (bus.m_data[1] !== 8'hC3) begin n_fail++; $display("FAIL glitch_word1: got %h expected c3", bus.m_data[1]); end
    endtask

    task automatic test_overrun();
        bus.m_ready = 1'b0;
        do_reset();
        tx_frame(8'h11, 8'h22);
        n_checks++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b expected 1", bus.m_valid); end
        n_checks++; if (bus.m_data !== 16'h2211) begin n_fail++; $display("FAIL ovr_first_data: got %h expected 2211", bus.m_data); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_not_yet: got %b expected 0", overrun); end
        tx_frame(8'h33, 8'h44);
        n_checks++; if (bus.m_data[0] !== 8'h11) begin n_fail++; $display("FAIL ovr_word0_kept: got %h expected 11", bus.m_data[0]); end
        n_checks++; if (bus.m_data[1] !== 8'h22) begin n_fail++; $display("FAIL ovr_word1_kept: got %h expected 22", bus.m_data[1]); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        bus.m_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: got %b expected 0", bus.m_valid); end
    endtask

    task automatic test_frame_err();
        logic exp_err;
`ifdef UART_RX_FRAME_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        bus.m_ready = 1'b1;
        do_reset();
        tx_word(8'h55, 1'b0);
        tx_word(8'h66, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++; if (frame_err !== exp_err) begin n_fail++; $display("FAIL frame_err_flag: got %b expected %b", frame_err, exp_err); end
        n_checks++; if (bus.m_data !== 16'h6655) begin n_fail++; $display("FAIL frame_err_stored: got %h expected 6655", bus.m_data); end
    endtask

    task automatic test_reset_mid();
        int base;
        bus.m_ready = 1'b1;
        tx_word(8'h77, 1'b1);
        do_reset();
        base = valid_cycles;
        tx_frame(8'h01, 8'h02);
        n_checks++; if (valid_cycles - base !== 1) begin n_fail++; $display("FAIL rstmid_valid: got %0d cycles expected 1", valid_cycles - base); end
        n_checks++; if (bus.m_data[0] !== 8'h01) begin n_fail++; $display("FAIL rstmid_word0: got %h expected 01", bus.m_data[0]); end
        n_checks++; if (bus.m_data[1] !== 8'h02) begin n_fail++; $display("FAIL rstmid_word1: got %h expected 02", bus.m_data[1]); end
    endtask

    initial begin
        rstn = 1'b0;
        rx = 1'b1;
        bus.m_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_loopback();
        test_glitch();
        test_overrun();
        test_frame_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
